// File: rtl/udp_pkg.sv
// Shared constants, FSM encoding and TX word payload for the UDP transmit framer.
package udp_pkg;

  localparam int unsigned LEN_W       = 11;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 9;
  localparam int unsigned CSUM_CYCLES = 3;
  localparam int unsigned GAP_CYCLES  = 2;

  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam int unsigned HDR_WORDS    = 11;
  localparam int unsigned MAX_PAYLOAD  = 1472;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    REQ,
    HDR,
    PAY,
    GAP
  } state_e;

  typedef struct packed {
    logic              wren;
    logic              sop;
    logic              eop;
    logic [1:0]        mod;
    logic [DATA_W-1:0] data;
  } tx_word_t;

endpackage

// File: rtl/udp_ip_csum.sv
// Three-stage IPv4 header checksum: variable-field sum, add fixed address sum, fold and invert.
module udp_ip_csum
  import udp_pkg::*;
#(
  parameter logic [31:0] SRC_IP = 32'h0,
  parameter logic [31:0] DST_IP = 32'h0,
  parameter logic [7:0]  TTL    = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] total_len_i,
  input  logic [15:0] ident_i,
  output logic [15:0] csum_o
);

  localparam logic [17:0] IP_SUM = 18'(SRC_IP[31:16]) + 18'(SRC_IP[15:0]) +
                                   18'(DST_IP[31:16]) + 18'(DST_IP[15:0]);

  logic [18:0] s1_q, s1_d;
  logic [19:0] s2_q, s2_d;
  logic [15:0] csum_q, csum_d;
  logic [16:0] fold1_c;
  logic [15:0] fold2_c;

  // Checksum field itself contributes zero to the sum.
  always_comb begin
    s1_d    = 19'(16'h4500) + 19'(total_len_i) + 19'(ident_i) +
              19'(16'h4000) + 19'({TTL, IP_PROTO_UDP});
    s2_d    = 20'(s1_q) + 20'(IP_SUM);
    fold1_c = 17'(s2_q[15:0]) + 17'(s2_q[19:16]);
    fold2_c = fold1_c[15:0] + 16'(fold1_c[16]);
    csum_d  = ~fold2_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      csum_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/udp_tx_framer.sv
// Builds an Ethernet/IPv4/UDP frame around a payload held in RAM and streams it to the TX arbiter.
module udp_tx_framer
  import udp_pkg::*;
#(
  parameter logic [47:0] SRC_MAC  = 48'h0,
  parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
  parameter logic [31:0] SRC_IP   = 32'h0,
  parameter logic [31:0] DST_IP   = 32'h0,
  parameter logic [15:0] SRC_PORT = 16'd0,
  parameter logic [15:0] DST_PORT = 16'd0,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  pl_len,
  output logic              busy,
  output logic              len_err,
  output logic [ADDR_W-1:0] pl_rd_addr,
  input  logic [DATA_W-1:0] pl_rd_data,
  output logic              en_udp,
  input  logic              tx_rdy,
  output logic              tx_wren,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [1:0]        tx_mod,
  output logic [DATA_W-1:0] tx_data
);

  localparam int unsigned LP3_W = LEN_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       ident_q, ident_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              len_err_q, len_err_d;
  logic              en_udp_q, en_udp_d;
  tx_word_t          tx_q, tx_d;

  logic [15:0]       csum_c;
  logic [15:0]       total_len_c;
  logic [15:0]       udp_len_c;
  logic [LP3_W-1:0]  len_p3_c;
  logic [CNT_W-1:0]  last_idx_c;
  logic [1:0]        mod_c;
  logic              len_ok_c;
  logic [3:0]        hdr_idx_c;
  logic [DATA_W-1:0] hdr_word_c;

  assign total_len_c = 16'(len_q) + 16'd28;
  assign udp_len_c   = 16'(len_q) + 16'd8;
  assign len_p3_c    = {1'b0, len_q} + LP3_W'(3);
  assign last_idx_c  = CNT_W'(len_p3_c >> 2) - CNT_W'(1);
  assign mod_c       = 2'(3'd4 - {1'b0, len_q[1:0]});
  assign len_ok_c    = (pl_len != '0) && (pl_len <= LEN_W'(MAX_PAYLOAD));

  udp_ip_csum #(
    .SRC_IP (SRC_IP),
    .DST_IP (DST_IP),
    .TTL    (TTL)
  ) u_csum (
    .clk         (clk),
    .rst_n       (rst_n),
    .total_len_i (total_len_c),
    .ident_i     (ident_q),
    .csum_o      (csum_c)
  );

  // Index of the header word loaded at the next edge (w0 is loaded from REQ).
  assign hdr_idx_c = (state_q == HDR) ? 4'(cnt_q) + 4'd1 : 4'd0;

  always_comb begin
    hdr_word_c = '0;
    case (hdr_idx_c)
      4'd0:    hdr_word_c = {16'h0000, DST_MAC[47:32]};
      4'd1:    hdr_word_c = DST_MAC[31:0];
      4'd2:    hdr_word_c = SRC_MAC[47:16];
      4'd3:    hdr_word_c = {SRC_MAC[15:0], ETH_TYPE_IP};
      4'd4:    hdr_word_c = {8'h45, 8'h00, total_len_c};
      4'd5:    hdr_word_c = {ident_q, 16'h4000};
      4'd6:    hdr_word_c = {TTL, IP_PROTO_UDP, csum_c};
      4'd7:    hdr_word_c = SRC_IP;
      4'd8:    hdr_word_c = DST_IP;
      4'd9:    hdr_word_c = {SRC_PORT, DST_PORT};
      4'd10:   hdr_word_c = {udp_len_c, 16'h0000};
      default: hdr_word_c = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ident_d   = ident_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    len_err_d = 1'b0;
    en_udp_d  = 1'b0;
    tx_d      = '0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          if (len_ok_c) begin
            len_d   = pl_len;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = CSUM;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      CSUM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CSUM_CYCLES - 1)) begin
          cnt_d    = '0;
          en_udp_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (tx_rdy) begin
          cnt_d     = '0;
          tx_d.wren = 1'b1;
          tx_d.sop  = 1'b1;
          tx_d.data = hdr_word_c;
          state_d   = HDR;
        end else begin
          en_udp_d = 1'b1;
        end
      end
      HDR: begin
        tx_d.wren = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // Payload read for word 0 is presented during w9 to cover the RAM latency.
        if (cnt_q >= CNT_W'(HDR_WORDS - 2)) addr_d = addr_q + ADDR_W'(1);
        if (cnt_q == CNT_W'(HDR_WORDS - 1)) begin
          cnt_d     = '0;
          tx_d.data = pl_rd_data;
          tx_d.eop  = (last_idx_c == '0);
          state_d   = PAY;
        end else begin
          tx_d.data = hdr_word_c;
        end
      end
      PAY: begin
        if (tx_q.eop) begin
          cnt_d   = '0;
          addr_d  = '0;
          ident_d = ident_q + 16'd1;
          state_d = GAP;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          addr_d    = addr_q + ADDR_W'(1);
          tx_d.wren = 1'b1;
          tx_d.data = pl_rd_data;
          tx_d.eop  = ((cnt_q + CNT_W'(1)) == last_idx_c);
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (tx_d.eop) tx_d.mod = mod_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      ident_q   <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      en_udp_q  <= 1'b0;
      tx_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ident_q   <= ident_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
      en_udp_q  <= en_udp_d;
      tx_q      <= tx_d;
    end
  end

  assign busy       = busy_q;
  assign len_err    = len_err_q;
  assign pl_rd_addr = addr_q;
  assign en_udp     = en_udp_q;
  assign tx_wren    = tx_q.wren;
  assign tx_sop     = tx_q.sop;
  assign tx_eop     = tx_q.eop;
  assign tx_mod     = tx_q.mod;
  assign tx_data    = tx_q.data;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: frame contents, checksum, arbitration wait, rejects, overlap and reset.
module tb_udp_tx_framer;

  localparam logic [47:0] T_SRC_MAC  = 48'h001122334455;
  localparam logic [47:0] T_DST_MAC  = 48'hFFFFFFFFFFFF;
  localparam logic [31:0] T_SRC_IP   = 32'hC0A80001;
  localparam logic [31:0] T_DST_IP   = 32'hC0A800FF;
  localparam logic [15:0] T_SRC_PORT = 16'h1234;
  localparam logic [15:0] T_DST_PORT = 16'h5678;
  localparam logic [7:0]  T_TTL      = 8'd64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] pl_len;
  logic        busy;
  logic        len_err;
  logic [8:0]  pl_rd_addr;
  logic [31:0] pl_rd_data;
  logic        en_udp;
  logic        tx_rdy;
  logic        tx_wren;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_mod;
  logic [31:0] tx_data;

  int n_checks;
  int n_errors;
  logic [15:0] exp_ident;

  logic [31:0] cap_data [512];
  logic        cap_sop  [512];
  logic        cap_eop  [512];
  logic [1:0]  cap_mod  [512];
  int          nw;

  udp_tx_framer #(
    .SRC_MAC  (T_SRC_MAC),
    .DST_MAC  (T_DST_MAC),
    .SRC_IP   (T_SRC_IP),
    .DST_IP   (T_DST_IP),
    .SRC_PORT (T_SRC_PORT),
    .DST_PORT (T_DST_PORT),
    .TTL      (T_TTL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pl_len     (pl_len),
    .busy       (busy),
    .len_err    (len_err),
    .pl_rd_addr (pl_rd_addr),
    .pl_rd_data (pl_rd_data),
    .en_udp     (en_udp),
    .tx_rdy     (tx_rdy),
    .tx_wren    (tx_wren),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .tx_mod     (tx_mod),
    .tx_data    (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload RAM with one-cycle read latency; contents depend only on the address.
  always @(posedge clk) pl_rd_data <= 32'hC0DE0000 + 32'(pl_rd_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_csum(input int len, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'(16'(len + 28)) + 32'(id) + 32'h4000 + 32'({T_TTL, 8'h11}) +
        32'(T_SRC_IP[31:16]) + 32'(T_SRC_IP[15:0]) + 32'(T_DST_IP[31:16]) + 32'(T_DST_IP[15:0]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  function automatic logic [31:0] exp_hdr(input int i, input int len, input logic [15:0] id,
                                          input logic [15:0] cs);
    case (i)
      0:       return {16'h0000, T_DST_MAC[47:32]};
      1:       return T_DST_MAC[31:0];
      2:       return T_SRC_MAC[47:16];
      3:       return {T_SRC_MAC[15:0], 16'h0800};
      4:       return {8'h45, 8'h00, 16'(len + 28)};
      5:       return {id, 16'h4000};
      6:       return {T_TTL, 8'h11, cs};
      7:       return T_SRC_IP;
      8:       return T_DST_IP;
      9:       return {T_SRC_PORT, T_DST_PORT};
      default: return {16'(len + 8), 16'h0000};
    endcase
  endfunction

  function automatic logic [31:0] idle_outs();
    return 32'({busy, len_err, en_udp, tx_wren, tx_sop, tx_eop, tx_mod, pl_rd_addr});
  endfunction

  // Sends one frame; poke_at injects a start while word poke_at is due, abort_at drops reset there.
  task automatic send_frame(input int len, input int rdy_delay, input int poke_at, input int abort_at);
    int  t;
    int  exp_n;
    int  bad_wait;
    bit  gap;
    bit  poked;
    bit  lerr_seen;
    logic [15:0] cs;
    logic [31:0] exp_w;
    nw = 0; bad_wait = 0; gap = 1'b0; poked = 1'b0; lerr_seen = 1'b0;
    start = 1'b1; pl_len = 11'(len); tx_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_set", 32'(busy), 32'd1);
    t = 0;
    while (!en_udp && t < 10) begin @(negedge clk); t++; end
    check("en_udp_rise", 32'(en_udp), 32'd1);
    for (int i = 0; i < rdy_delay; i++) begin
      if (!en_udp || tx_wren || tx_data != 32'd0) bad_wait++;
      @(negedge clk);
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
    check("en_udp_drop", 32'(en_udp), 32'd0);
    check("rdy_wait", 32'(bad_wait), 32'd0);
    t = 0;
    while (t < 500) begin
      if (abort_at > 0 && nw == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_outs", idle_outs(), 32'd0);
        check("abort_data", tx_data, 32'd0);
        return;
      end
      if (tx_wren) begin
        cap_data[nw] = tx_data; cap_sop[nw] = tx_sop; cap_eop[nw] = tx_eop; cap_mod[nw] = tx_mod;
        nw++;
        if (tx_eop) break;
      end else begin
        gap = 1'b1;
      end
      if (poke_at > 0 && nw == poke_at && !poked) begin
        start = 1'b1; pl_len = 11'd4; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (len_err) lerr_seen = 1'b1;
      t++;
    end
    start = 1'b0;
    exp_n = 11 + (len + 3) / 4;
    cs = ref_csum(len, exp_ident);
    check("word_count", 32'(nw), 32'(exp_n));
    check("no_gap", 32'(gap), 32'd0);
    check("no_len_err", 32'(lerr_seen), 32'd0);
    for (int i = 0; i < nw && i < exp_n; i++) begin
      exp_w = (i < 11) ? exp_hdr(i, len, exp_ident, cs) : 32'hC0DE0000 + 32'(i - 11);
      check($sformatf("word%0d", i), cap_data[i], exp_w);
      check($sformatf("sop%0d", i), 32'(cap_sop[i]), 32'(i == 0));
      check($sformatf("eop%0d", i), 32'(cap_eop[i]), 32'(i == exp_n - 1));
      check($sformatf("mod%0d", i), 32'(cap_mod[i]), (i == exp_n - 1) ? 32'((4 - len % 4) % 4) : 32'd0);
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check("gap_outs", idle_outs(), 32'h10000);
      check("gap_data", tx_data, 32'd0);
    end
    @(negedge clk);
    check("busy_clear", 32'(busy), 32'd0);
    exp_ident = exp_ident + 16'd1;
  endtask

  task automatic reject(input int len);
    start = 1'b1; pl_len = 11'(len);
    @(negedge clk);
    start = 1'b0;
    check("len_err_pulse", 32'(len_err), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("len_err_clear", 32'(len_err), 32'd0);
    check("rej_idle", 32'(busy | en_udp), 32'd0);
  endtask

  initial begin
    logic [31:0] s;
    int quiet;
    n_checks = 0; n_errors = 0; exp_ident = 16'd0;
    start = 1'b0; pl_len = '0; tx_rdy = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", idle_outs(), 32'd0);
    check("reset_data", tx_data, 32'd0);
    rst_n = 1'b1;

    // Checksum reference case, first frame after reset so ident is 0.
    send_frame(18, 0, 0, 0);
    check("csum_hand", 32'(cap_data[6][15:0]), 32'h0000B86E);
    s = 32'd0;
    for (int i = 4; i <= 8; i++) s = s + 32'(cap_data[i][31:16]) + 32'(cap_data[i][15:0]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    check("csum_refold", 32'(s[15:0]), 32'h0000FFFF);

    send_frame(4, 0, 0, 0);
    check("len4_total", 32'(cap_data[4][15:0]), 32'h20);
    check("len4_udp", 32'(cap_data[10][31:16]), 32'h0C);

    send_frame(5, 20, 0, 0);
    check("len5_eop_word", cap_data[12], 32'hC0DE0001);
    check("len5_mod", 32'(cap_mod[12]), 32'd3);
    check("len5_total", 32'(cap_data[4][15:0]), 32'h21);

    reject(0);
    reject(1473);

    send_frame(1, 0, 0, 0);
    send_frame(6, 2, 0, 0);
    send_frame(7, 0, 0, 0);
    send_frame(1472, 1, 0, 0);

    // Start during payload must not launch a second frame.
    send_frame(40, 0, 13, 0);
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || en_udp || tx_wren) quiet++;
    end
    check("single_frame", 32'(quiet), 32'd0);

    send_frame(40, 0, 0, 13);
    @(negedge clk);
    check("abort_hold", idle_outs(), 32'd0);
    rst_n = 1'b1;
    exp_ident = 16'd0;
    send_frame(8, 0, 0, 0);
    check("post_reset_ident", 32'(cap_data[5][31:16]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_framer.md
UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

Interface
REQ-001 Parameters SHALL be:
- SRC_MAC: 48'h0, source MAC.
- DST_MAC: 48'hFFFFFFFFFFFF, destination MAC.
- SRC_IP: 32'h0, source IPv4 address.
- DST_IP: 32'h0, destination IPv4 address.
- SRC_PORT: 16'd0, UDP source port.
- DST_PORT: 16'd0, UDP destination port.
- TTL: 8'd64, IP time-to-live.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle send request.
- pl_len  in  11  payload length in bytes, sampled with start.
- busy  out  1  high from accepted start until return to IDLE.
- len_err  out  1  one-cycle pulse on a rejected start.
- pl_rd_addr  out  9  payload RAM word address.
- pl_rd_data  in  32  payload RAM data, 1-cycle read latency.
- en_udp  out  1  request to the TX arbiter.
- tx_rdy  in  1  grant/ready returned by the arbiter.
- tx_wren  out  1  word valid.
- tx_sop  out  1  first word of frame.
- tx_eop  out  1  last word of frame.
- tx_mod  out  2  invalid trailing bytes in the eop word.
- tx_data  out  32  frame word; byte 0 is on [31:24].

Function
REQ-003 States SHALL be IDLE, CSUM, REQ, HDR, PAY and GAP.
REQ-004 In IDLE, start with 1<=pl_len<=1472 SHALL latch pl_len, set busy and go to CSUM. Any other pl_len SHALL pulse len_err and remain in IDLE.
REQ-005 start while busy=1 SHALL be ignored, with no len_err.
REQ-006 CSUM SHALL last exactly 3 cycles and compute the IPv4 header checksum: 1's-complement 16-bit sum of header words, carry fold twice, invert. The checksum field is 0 during the sum.
REQ-007 REQ SHALL hold en_udp=1 until the first cycle with tx_rdy=1. In that cycle en_udp SHALL drop to 0 and the state SHALL become HDR.
REQ-008 HDR SHALL emit 11 words on consecutive cycles with tx_wren=1, big-endian:
- w0 = 16'h0000 pad, DST_MAC[47:32]
- w1 = DST_MAC[31:0]
- w2 = SRC_MAC[47:16]
- w3 = SRC_MAC[15:0], 16'h0800
- w4 = 8'h45, 8'h00, total_len = len+28
- w5 = ident, 16'h4000
- w6 = TTL, 8'h11, checksum
- w7 = SRC_IP
- w8 = DST_IP
- w9 = SRC_PORT, DST_PORT
- w10 = udp_len = len+8, 16'h0000
REQ-009 tx_sop SHALL be 1 on w0 only.
REQ-010 PAY SHALL emit ceil(len/4) words from pl_rd_addr = 0, 1, ... contiguously after w10. The read for address 0 SHALL be issued during w9 so there is no bubble.
REQ-011 tx_wren SHALL stay 1 from w0 through the eop word with no gaps. The arbiter ends a grant on the first wren low, so tx_rdy is ignored once HDR starts; the MAC guarantees space for one maximum frame whenever it asserts ready.
REQ-012 tx_eop SHALL be 1 on the last payload word only, with tx_mod = (4 - len mod 4) mod 4. tx_mod SHALL be 0 on all other words.
REQ-013 tx_data SHALL be 0 whenever tx_wren=0.
REQ-014 After eop, GAP SHALL hold all outputs idle for 2 cycles so the arbiter frees its flag, then go to IDLE and clear busy.
REQ-015 ident SHALL be a 16-bit counter that increments after each eop and wraps from FFFF to 0000.
REQ-016 All tx_* outputs and en_udp SHALL be registered.

Reset
REQ-017 On rst_n=0, at any time including mid-frame:
- state = IDLE
- ident = 0
- outputs busy, len_err, en_udp, tx_wren, tx_sop, tx_eop, tx_mod, tx_data and pl_rd_addr = 0
- any frame in progress is abandoned with no eop.
REQ-018 After rst_n rises, the first start SHALL be accepted on the first clk edge.

Structure
REQ-019 A shared package udp_pkg SHALL hold:
- ETH_TYPE_IP = 16'h0800
- IP_PROTO_UDP = 8'h11
- HDR_WORDS = 11
- MAX_PAYLOAD = 1472
- the state encoding
REQ-020 The checksum datapath SHALL be one sub-module, udp_ip_csum: 3-cycle pipeline, inputs are the header fields, output is 16-bit checksum.

Verification
REQ-021 Length 4, tx_rdy=1 -> 12 wren cycles; sop on w0; eop on w11; mod 0; w4[15:0]=16'h0020; w10[31:16]=16'h000C.
REQ-022 Length 5 -> 13 words; eop word = RAM word 1; mod=3; total_len 16'h0021.
REQ-023 Checksum case: SRC_IP C0A80001, DST_IP C0A800FF, len 18, ident 0, TTL 64 -> w6[15:0] equals a reference-model checksum, and the header refolds to FFFF.
REQ-024 tx_rdy held 0 for 20 cycles -> en_udp=1 throughout with no wren. tx_rdy=1 -> en_udp low next cycle, and w0 follows.
REQ-025 Rejects and overlap: pl_len 0 or 1473 -> len_err pulse, busy stays 0. start during PAY -> ignored, exactly one frame sent.
REQ-026 rst_n low during PAY -> all outputs 0 immediately. A start after release -> a complete frame with ident=0.
